// File: rtl/ekf_pkg.sv
// rtl/ekf_pkg.sv - shared EKF constants: CB lane-map select codes, element counts, write FSM states
package ekf_pkg;

  localparam logic [1:0] CB_SEL_IDLE   = 2'b00;
  localparam logic [1:0] CB_SEL_XYXITA = 2'b10;
  localparam logic [1:0] CB_SEL_LXLY   = 2'b11;

  localparam int N_POSE = 3;
  localparam int N_LM   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEQ  = 2'd1,
    S_LAST = 2'd2,
    S_FIN  = 2'd3
  } wr_state_t;

  function automatic int elem_count(input logic m);
    return m ? N_LM : N_POSE;
  endfunction

endpackage

// File: rtl/cb_wr_seq.sv
// rtl/cb_wr_seq.sv - sequences pose/landmark element writes into the banked CB memory
module cb_wr_seq
  import ekf_pkg::*;
#(
  parameter int L              = 4,
  parameter int SEQ_CNT_DW     = 5,
  parameter int CB_DINA_SEL_DW = 2,
  parameter int CB_AW          = 10,
  parameter int MAX_LM         = 64
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic [CB_AW-1:0]          lm_idx,
  output logic [CB_DINA_SEL_DW-1:0] CB_dina_sel,
  output logic [SEQ_CNT_DW-1:0]     seq_cnt_out,
  output logic                      CB_ena,
  output logic [L-1:0]              CB_wea,
  output logic [CB_AW-1:0]          CB_addra,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  wr_state_t                 state, state_n;
  logic [SEQ_CNT_DW-1:0]     cnt, cnt_n;
  logic [CB_DINA_SEL_DW-1:0] sel, sel_n;
  logic                      cur_mode, cur_mode_n;
  logic [CB_AW-1:0]          addr, addr_n;
  logic                      pend_valid, pend_valid_n;
  logic                      pend_mode, pend_mode_n;
  logic [CB_AW-1:0]          pend_idx, pend_idx_n;
  logic                      err_n;
  logic                      req_ok;
  logic                      launch, can_queue;
  logic                      l_mode;
  logic [CB_AW-1:0]          l_idx;

  assign req_ok = start && !(mode && (32'(lm_idx) >= MAX_LM));

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    sel_n        = sel;
    cur_mode_n   = cur_mode;
    addr_n       = addr;
    pend_valid_n = pend_valid;
    pend_mode_n  = pend_mode;
    pend_idx_n   = pend_idx;
    err_n        = 1'b0;
    launch       = 1'b0;
    can_queue    = 1'b0;
    l_mode       = mode;
    l_idx        = lm_idx;

    case (state)
      S_IDLE: begin
        if (req_ok) launch = 1'b1;
      end
      S_SEQ: begin
        can_queue = 1'b1;
        if (cnt == SEQ_CNT_DW'(elem_count(cur_mode))) begin
          state_n = S_LAST;
          cnt_n   = '0;
          sel_n   = CB_DINA_SEL_DW'(CB_SEL_IDLE);
        end else begin
          cnt_n = cnt + SEQ_CNT_DW'(1);
        end
      end
      S_LAST: begin
        can_queue = 1'b1;
        state_n   = S_FIN;
      end
      S_FIN: begin
        // A held request wins; a fresh start then sees a full slot and is dropped.
        if (pend_valid) begin
          launch       = 1'b1;
          can_queue    = 1'b1;
          l_mode       = pend_mode;
          l_idx        = pend_idx;
          pend_valid_n = 1'b0;
        end else if (req_ok) begin
          launch = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (can_queue && req_ok) begin
      if (pend_valid) begin
        err_n = 1'b1;
      end else begin
        pend_valid_n = 1'b1;
        pend_mode_n  = mode;
        pend_idx_n   = lm_idx;
      end
    end

    if (start && !req_ok) err_n = 1'b1;

    if (launch) begin
      state_n    = S_SEQ;
      cnt_n      = SEQ_CNT_DW'(1);
      sel_n      = l_mode ? CB_DINA_SEL_DW'(CB_SEL_LXLY) : CB_DINA_SEL_DW'(CB_SEL_XYXITA);
      cur_mode_n = l_mode;
      addr_n     = l_mode ? l_idx + CB_AW'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sel        <= '0;
      cur_mode   <= 1'b0;
      addr       <= '0;
      pend_valid <= 1'b0;
      pend_mode  <= 1'b0;
      pend_idx   <= '0;
      err        <= 1'b0;
      CB_ena     <= 1'b0;
      CB_wea     <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel        <= sel_n;
      cur_mode   <= cur_mode_n;
      addr       <= addr_n;
      pend_valid <= pend_valid_n;
      pend_mode  <= pend_mode_n;
      pend_idx   <= pend_idx_n;
      err        <= err_n;
      // Enables trail the counter by one cycle to line up with the registered lane mapper.
      CB_ena     <= (cnt != '0);
      CB_wea     <= (cnt != '0) ? (L'(1) << (cnt - SEQ_CNT_DW'(1))) : '0;
    end
  end

  assign seq_cnt_out = cnt;
  assign CB_dina_sel = sel;
  assign CB_addra    = addr;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);

endmodule
